dither_pipe_param: RTL and testbench

Parametrised per-channel colour-depth reducer for the VGA pixel path. It sits between the frame/pixel source and the VGA DAC output register. It replaces the fixed 3×8→4-bit combinational ditherer with a registered, mode-selectable unit. Modes are bypass, plain truncation, ordered (Bayer) dithering with an internal screen-position tracker, and 1-D error diffusion along each line.

---
 rtl/dither_pipe_param_if.sv | 25 ++
 rtl/dither_pipe_param.sv | 160 ++++++++++++++++
 tb/tb_dither_pipe_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dither_pipe_param_if.sv
// Pixel-path bundle for the colour-depth reducer.
//   master: pixel source (drives mode, visible, line_end, frame_end, data_in)
//   slave : reducer (drives data_out, visible_out)
interface dither_pipe_param_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned IN_W     = 8
);
  logic [1:0]               mode;
  logic                     visible;
  logic                     line_end;
  logic                     frame_end;
  logic [CHANNELS*IN_W-1:0] data_in;
  logic [CHANNELS*IN_W-1:0] data_out;
  logic                     visible_out;

  modport master (
    output mode, visible, line_end, frame_end, data_in,
    input  data_out, visible_out
  );

  modport slave (
    input  mode, visible, line_end, frame_end, data_in,
    output data_out, visible_out
  );
endinterface

// File: rtl/dither_pipe_param.sv
// Registered per-channel colour-depth reducer for the VGA pixel path.
// Modes: bypass, truncate, ordered (Bayer) dither, 1-D error diffusion.
// Fixed 2-cycle latency in every mode.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset
//   px   - pixel bundle (slave): mode/visible/line_end/frame_end/data_in in,
//          data_out/visible_out out; channel c at [c*IN_W +: IN_W]
module dither_pipe_param #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 4,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned BAYER_N  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dither_pipe_param_if.slave   px
);

  localparam int unsigned D   = IN_W - OUT_W;
  localparam int unsigned M_W = 2 * BAYER_N;
  localparam int unsigned S_W = IN_W + 1;
  localparam int unsigned DW  = CHANNELS * IN_W;
  localparam int unsigned EW  = CHANNELS * D;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_TRUNC   = 2'd1,
    MODE_ORDERED = 2'd2,
    MODE_DIFFUSE = 2'd3
  } mode_e;

  // Reject parameter sets where the threshold would not fit below the kept bits.
  if (OUT_W < 1 || OUT_W >= IN_W || BAYER_N < 1 || BAYER_N > 3 ||
      IN_W - OUT_W < 2 * BAYER_N) begin : g_bad_params
    $error("dither_pipe_param: illegal IN_W/OUT_W/BAYER_N combination");
  end

  // Bayer entry by bit interleaving: coordinate bit i selects the 2x2 base
  // pattern [[0,2],[3,1]] at weight 4^(BAYER_N-1-i), so the finest coordinate
  // bit lands in the most significant value bits.
  function automatic logic [M_W-1:0] bayer_val(input logic [BAYER_N-1:0] yy,
                                                input logic [BAYER_N-1:0] xx);
    logic [M_W-1:0] v;
    v = '0;
    for (int i = 0; i < BAYER_N; i++) begin
      v[2*(BAYER_N-1-i)+1] = xx[i] ^ yy[i];
      v[2*(BAYER_N-1-i)]   = yy[i];
    end
    return v;
  endfunction

  logic [BAYER_N-1:0] pos_x, pos_y;
  logic [D-1:0]       thr_c;

  logic [DW-1:0]      s1_data;
  mode_e              s1_mode;
  logic               s1_vis;
  logic               s1_clr;
  logic [D-1:0]       s1_thr;

  logic [EW-1:0]      err_q, err_nxt_c;
  logic [DW-1:0]      out_c;

  // Screen-position tracker; the pixel on a line_end cycle still uses the current x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (px.frame_end) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (px.line_end) begin
      pos_x <= '0;
      pos_y <= pos_y + BAYER_N'(1);
    end else if (px.visible) begin
      pos_x <= pos_x + BAYER_N'(1);
    end
  end

  assign thr_c = D'(bayer_val(pos_y, pos_x)) << (D - M_W);

  // Stage 1: capture pixel, control and threshold together so mode switches are pixel-exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data <= '0;
      s1_mode <= MODE_BYPASS;
      s1_vis  <= 1'b0;
      s1_clr  <= 1'b0;
      s1_thr  <= '0;
    end else begin
      s1_data <= px.data_in;
      s1_mode <= mode_e'(px.mode);
      s1_vis  <= px.visible;
      s1_clr  <= px.line_end | px.frame_end;
      s1_thr  <= thr_c;
    end
  end

  // Stage 2 datapath: per-channel quantisation and next diffusion error.
  always_comb begin
    logic [IN_W-1:0]  din;
    logic [D-1:0]     e;
    logic [S_W-1:0]   sum;
    logic [OUT_W-1:0] q;
    out_c     = '0;
    err_nxt_c = '0;
    din       = '0;
    e         = '0;
    sum       = '0;
    q         = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      din = s1_data[c*IN_W +: IN_W];
      e   = err_q[c*D +: D];
      sum = '0;
      q   = '0;
      unique case (s1_mode)
        MODE_BYPASS: ;
        MODE_TRUNC: begin
          if (s1_vis) q = din[IN_W-1:D];
        end
        MODE_ORDERED: begin
          if (s1_vis) begin
            sum = S_W'(din) + S_W'(s1_thr);
            q   = sum[IN_W] ? '1 : sum[IN_W-1:D];
          end
        end
        MODE_DIFFUSE: begin
          if (s1_vis) begin
            sum = S_W'(din) + S_W'(e);
            if (sum[IN_W]) begin
              q = '1;
            end else begin
              q = sum[IN_W-1:D];
              err_nxt_c[c*D +: D] = sum[D-1:0];
            end
          end
        end
      endcase
      if (s1_mode == MODE_BYPASS) out_c[c*IN_W +: IN_W] = din;
      else                        out_c[c*IN_W +: IN_W] = {q, {D{1'b0}}};
    end
    // Error never carries across a line or frame boundary.
    if (s1_clr) err_nxt_c = '0;
  end

  // Stage 2 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px.data_out    <= '0;
      px.visible_out <= 1'b0;
      err_q          <= '0;
    end else begin
      px.data_out    <= out_c;
      px.visible_out <= s1_vis;
      err_q          <= err_nxt_c;
    end
  end

endmodule

// File: tb/tb_dither_pipe_param.sv
// Randomised self-checking bench for dither_pipe_param against a
// matrix/queue based reference model.
module tb_dither_pipe_param;

  localparam int unsigned IN_W    = 8;
  localparam int unsigned OUT_W   = 4;
  localparam int unsigned CH      = 3;
  localparam int unsigned BAYER_N = 2;
  localparam int unsigned D       = IN_W - OUT_W;
  localparam int unsigned DW      = CH * IN_W;
  localparam int          SIDE    = 1 << BAYER_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dither_pipe_param_if #(.CHANNELS(CH), .IN_W(IN_W)) bus ();

  dither_pipe_param #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .BAYER_N(BAYER_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .px  (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int mat [8][8];
  int mx, my;
  int err [CH];
  logic [DW-1:0] exp_d [$];
  logic          exp_v [$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Build the Bayer matrix from the recursive definition.
  task automatic build_matrix();
    int base [2][2];
    int tmp [8][8];
    int s;
    base[0][0] = 0; base[0][1] = 2; base[1][0] = 3; base[1][1] = 1;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) mat[y][x] = base[y][x];
    s = 2;
    while (s < SIDE) begin
      for (int y = 0; y < 2*s; y++)
        for (int x = 0; x < 2*s; x++)
          tmp[y][x] = 4 * mat[y % s][x % s] + base[y / s][x / s];
      for (int y = 0; y < 2*s; y++)
        for (int x = 0; x < 2*s; x++) mat[y][x] = tmp[y][x];
      s = 2 * s;
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    for (int c = 0; c < CH; c++) err[c] = 0;
    exp_d.delete(); exp_v.delete();
    // pipeline holds reset values for the first two samples
    exp_d.push_back('0); exp_v.push_back(1'b0);
    exp_d.push_back('0); exp_v.push_back(1'b0);
  endtask

  task automatic set_idle();
    bus.mode = 2'd0; bus.visible = 1'b0; bus.line_end = 1'b0;
    bus.frame_end = 1'b0; bus.data_in = '0;
  endtask

  // One pixel clock: check the output due now, drive new inputs, predict their output.
  task automatic step(input logic [1:0] m, input logic v, input logic le,
                      input logic fe, input logic [DW-1:0] d);
    logic [DW-1:0] ed;
    int thr, in, s, o, sat;
    @(negedge clk);
    if (exp_d.size() >= 2) begin
      chk("data_out", bus.data_out, exp_d.pop_front());
      chk("visible_out", DW'(bus.visible_out), DW'(exp_v.pop_front()));
    end
    bus.mode = m; bus.visible = v; bus.line_end = le; bus.frame_end = fe; bus.data_in = d;

    sat = ((1 << OUT_W) - 1) << D;
    thr = mat[my][mx] << (D - 2*BAYER_N);
    ed  = '0;
    for (int c = 0; c < CH; c++) begin
      in = int'(d[c*IN_W +: IN_W]);
      o  = 0;
      if (m == 2'd0) o = in;
      else if (v) begin
        case (m)
          2'd1: o = (in / (1 << D)) * (1 << D);
          2'd2: begin
            s = in + thr;
            o = (s >= (1 << IN_W)) ? sat : (s / (1 << D)) * (1 << D);
          end
          default: begin
            s = in + err[c];
            if (s >= (1 << IN_W)) begin
              o = sat; err[c] = 0;
            end else begin
              o = (s / (1 << D)) * (1 << D);
              err[c] = s % (1 << D);
            end
          end
        endcase
      end
      if (m != 2'd3 || !v || le || fe) err[c] = 0;
      ed[c*IN_W +: IN_W] = IN_W'(o);
    end
    exp_d.push_back(ed);
    exp_v.push_back(v);

    if (fe) begin mx = 0; my = 0; end
    else if (le) begin mx = 0; my = (my + 1) % SIDE; end
    else if (v) mx = (mx + 1) % SIDE;
  endtask

  function automatic logic [DW-1:0] rnd_pix();
    logic [DW-1:0] p;
    for (int c = 0; c < CH; c++)
      p[c*IN_W +: IN_W] = ($urandom_range(0, 3) == 0) ? IN_W'($urandom_range(240, 255))
                                                      : IN_W'($urandom);
    return p;
  endfunction

  initial begin
    build_matrix();
    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", bus.data_out, '0);
    chk("reset visible_out", DW'(bus.visible_out), '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // bypass ignores visible; truncate
    step(2'd0, 1'b0, 1'b0, 1'b0, 24'h123456);
    step(2'd1, 1'b1, 1'b0, 1'b0, 24'h7F80FF);

    // ordered dither at known positions
    step(2'd2, 1'b0, 1'b0, 1'b1, '0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd2, 1'b0, 1'b1, 1'b0, '0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'h757575);
    step(2'd2, 1'b0, 1'b1, 1'b0, '0);
    step(2'd2, 1'b0, 1'b1, 1'b0, '0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'hFFFFFF);

    // error diffusion: alternating run, line reset, saturation
    step(2'd3, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step(2'd3, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd3, 1'b1, 1'b1, 1'b0, 24'h787878);
    for (int i = 0; i < 3; i++) step(2'd3, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd3, 1'b1, 1'b0, 1'b0, 24'hFFFFFF);
    step(2'd3, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd1, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd3, 1'b1, 1'b0, 1'b0, 24'h787878);

    // tracker: 4 lines of 5 pixels, then a frame_end
    step(2'd2, 1'b0, 1'b0, 1'b1, '0);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 5; p++) step(2'd2, 1'b1, 1'b0, 1'b0, 24'h707070);
      step(2'd2, 1'b0, 1'b1, 1'b0, '0);
    end
    step(2'd2, 1'b0, 1'b0, 1'b1, '0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'h787878);

    // asynchronous reset between clock edges, mid-line
    for (int i = 0; i < 4; i++) step(2'd3, 1'b1, 1'b0, 1'b0, 24'hF7F7F7);
    #2;
    rst = 1'b1;
    set_idle();
    #1;
    chk("async data_out", bus.data_out, '0);
    chk("async visible_out", DW'(bus.visible_out), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(2'd3, 1'b1, 1'b0, 1'b0, 24'h787878);
    step(2'd2, 1'b1, 1'b0, 1'b0, 24'h787878);

    // randomised traffic
    begin
      logic [1:0] m;
      m = 2'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) m = 2'($urandom);
        step(m, ($urandom_range(0, 5) != 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 79) == 0), rnd_pix());
      end
    end

    // drain the pipeline
    step(2'd0, 1'b0, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b0, 1'b0, '0);
    step(2'd0, 1'b0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
